// File: rtl/fp16_pkg.sv
// fp16_pkg -- shared definitions for the half-precision mantissa alignment block.
//   Field widths, special-exponent limit, shift cap, exception codes,
//   alignment FSM state type and helpers that unpack an fp16 operand into
//   the aligned-mantissa layout:
//     bit13 = 0 (carry room), bit12 = hidden, [11:2] = frac, bit1 = guard,
//     bit0 = sticky.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int FRAC_W    = 10;
  localparam int MAN_W     = 16;
  localparam int OEXP_W    = 6;
  localparam int CNT_W     = 4;
  localparam int EXP_MAX   = 31;
  localparam int MAX_SHIFT = 13;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INF_NAN = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } align_state_t;

  // Subnormals (exp = 0) behave as exponent 1 with no hidden bit.
  function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

  function automatic logic [MAN_W-1:0] build_man(input logic [EXP_W-1:0]  e,
                                                 input logic [FRAC_W-1:0] f);
    return {2'b00, (e != '0), f, 2'b00};
  endfunction

endpackage

// File: rtl/align_mantissa_if.sv
// align_mantissa_if -- handshake bus of the mantissa alignment block.
//   Input side : in_valid/in_ready handshake, operands a, b (fp16).
//   Output side: out_valid/out_ready handshake, man_l, man_s, out_exp,
//                sign_l, sign_s, swapped, exception.
//   master = producer of operands / consumer of results (bench side),
//   slave  = the alignment block.
interface align_mantissa_if;
  import fp16_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [MAN_W-1:0]     a;
  logic [MAN_W-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [MAN_W-1:0]     man_l;
  logic [MAN_W-1:0]     man_s;
  logic [OEXP_W-1:0]    out_exp;
  logic                 sign_l;
  logic                 sign_s;
  logic                 swapped;
  logic [1:0]           exception;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, man_l, man_s, out_exp,
           sign_l, sign_s, swapped, exception
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, man_l, man_s, out_exp,
           sign_l, sign_s, swapped, exception
  );
endinterface

// File: rtl/align_mantissa_exp_compare.sv
// exp_compare -- combinational front end of the alignment block.
//   Ports:
//     i_a, i_b    : fp16 operands
//     o_swap      : 1 when b has the larger {exp, frac} magnitude (ties -> 0)
//     o_sign_l/s  : signs of larger / smaller operand
//     o_special   : either operand has exponent 31 (inf/NaN)
//     o_exp_l     : effective exponent of larger operand
//     o_shift     : alignment distance, capped at MAX_SHIFT
//     o_man_l/s   : unshifted aligned-layout mantissas of larger / smaller
module exp_compare
  import fp16_pkg::*;
(
  input  logic [MAN_W-1:0] i_a,
  input  logic [MAN_W-1:0] i_b,
  output logic             o_swap,
  output logic             o_sign_l,
  output logic             o_sign_s,
  output logic             o_special,
  output logic [EXP_W-1:0] o_exp_l,
  output logic [CNT_W-1:0] o_shift,
  output logic [MAN_W-1:0] o_man_l,
  output logic [MAN_W-1:0] o_man_s
);

  logic [EXP_W-1:0]  w_exp_a, w_exp_b, w_exp_s;
  logic [FRAC_W-1:0] w_frac_a, w_frac_b;
  logic [EXP_W-1:0]  w_diff;

  assign w_exp_a  = i_a[FRAC_W +: EXP_W];
  assign w_exp_b  = i_b[FRAC_W +: EXP_W];
  assign w_frac_a = i_a[FRAC_W-1:0];
  assign w_frac_b = i_b[FRAC_W-1:0];

  // Raw {exp, frac} ordering matches effective-value ordering, subnormals included.
  assign o_swap    = {w_exp_b, w_frac_b} > {w_exp_a, w_frac_a};
  assign o_sign_l  = o_swap ? i_b[MAN_W-1] : i_a[MAN_W-1];
  assign o_sign_s  = o_swap ? i_a[MAN_W-1] : i_b[MAN_W-1];
  assign o_special = (w_exp_a == EXP_W'(EXP_MAX)) || (w_exp_b == EXP_W'(EXP_MAX));

  assign o_exp_l = o_swap ? eff_exp(w_exp_b) : eff_exp(w_exp_a);
  assign w_exp_s = o_swap ? eff_exp(w_exp_a) : eff_exp(w_exp_b);
  assign w_diff  = o_exp_l - w_exp_s;
  assign o_shift = (w_diff > EXP_W'(MAX_SHIFT)) ? CNT_W'(MAX_SHIFT) : w_diff[CNT_W-1:0];

  assign o_man_l = o_swap ? build_man(w_exp_b, w_frac_b) : build_man(w_exp_a, w_frac_a);
  assign o_man_s = o_swap ? build_man(w_exp_a, w_frac_a) : build_man(w_exp_b, w_frac_b);

endmodule

// File: rtl/align_mantissa.sv
// align_mantissa -- aligns the mantissas of two fp16 operands ahead of an adder.
//   Ports:
//     clk   : sole clock, rising edge
//     rst_n : asynchronous active-low reset
//     bus   : align_mantissa_if.slave (operand and result handshakes)
//   Operation: accept in IDLE, shift the smaller mantissa right one bit per
//   SHIFT cycle (at most MAX_SHIFT cycles), hold the result in DONE until
//   out_ready. Exponent 31 on either operand bypasses SHIFT and flags an
//   exception with zeroed mantissas.
//   Build option: ALIGN_STICKY_EN -- when defined, bits shifted out of bit0
//   are ORed into bit0; otherwise they are truncated.
module align_mantissa
  import fp16_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  align_mantissa_if.slave  bus
);

  align_state_t      r_state;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [MAN_W-1:0]  r_man_l;
  logic [MAN_W-1:0]  r_man_s;
  logic [OEXP_W-1:0] r_out_exp;
  logic              r_sign_l;
  logic              r_sign_s;
  logic              r_swapped;
  logic [1:0]        r_exception;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_swap, w_sign_l, w_sign_s, w_special;
  logic [EXP_W-1:0]  w_exp_l;
  logic [CNT_W-1:0]  w_shift;
  logic [MAN_W-1:0]  w_man_l, w_man_s;

  function automatic logic [MAN_W-1:0] shift_right1(input logic [MAN_W-1:0] m);
    logic [MAN_W-1:0] r;
    r = m >> 1;
`ifdef ALIGN_STICKY_EN
    r[0] = m[1] | m[0];
`endif
    return r;
  endfunction

  exp_compare u_cmp (
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_swap   (w_swap),
    .o_sign_l (w_sign_l),
    .o_sign_s (w_sign_s),
    .o_special(w_special),
    .o_exp_l  (w_exp_l),
    .o_shift  (w_shift),
    .o_man_l  (w_man_l),
    .o_man_s  (w_man_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_man_l     <= '0;
      r_man_s     <= '0;
      r_out_exp   <= '0;
      r_sign_l    <= 1'b0;
      r_sign_s    <= 1'b0;
      r_swapped   <= 1'b0;
      r_exception <= EXC_NONE;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_in_ready <= 1'b0;
            r_sign_l   <= w_sign_l;
            r_sign_s   <= w_sign_s;
            r_swapped  <= w_swap;
            if (w_special) begin
              r_man_l     <= '0;
              r_man_s     <= '0;
              r_out_exp   <= OEXP_W'(EXP_MAX);
              r_exception <= EXC_INF_NAN;
              r_cnt       <= '0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_man_l     <= w_man_l;
              r_man_s     <= w_man_s;
              r_out_exp   <= {1'b0, w_exp_l};
              r_exception <= EXC_NONE;
              r_cnt       <= w_shift;
              if (w_shift == '0) begin
                r_out_valid <= 1'b1;
                r_state     <= S_DONE;
              end else begin
                r_state     <= S_SHIFT;
              end
            end
          end
        end
        S_SHIFT: begin
          r_man_s <= shift_right1(r_man_s);
          r_cnt   <= r_cnt - CNT_W'(1);
          // Last shift lands together with the DONE entry.
          if (r_cnt == CNT_W'(1)) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.man_l     = r_man_l;
  assign bus.man_s     = r_man_s;
  assign bus.out_exp   = r_out_exp;
  assign bus.sign_l    = r_sign_l;
  assign bus.sign_s    = r_sign_s;
  assign bus.swapped   = r_swapped;
  assign bus.exception = r_exception;

endmodule

// File: tb/tb_align_mantissa.sv
// tb_align_mantissa -- directed self-checking bench for align_mantissa.
//   Build option ALIGN_STICKY_EN selects sticky vs truncating expectations.
module tb_align_mantissa;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  align_mantissa_if bus ();

  align_mantissa dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Offer one operand pair at a falling edge; latency counts the accept
  // cycle as 0, so lat = cycle in which out_valid is first seen. 40 = timeout.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, output int lat);
    bus.a = a;
    bus.b = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic release_result();
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++; if (bus.man_l !== 16'h0000 || bus.man_s !== 16'h0000) begin failures++; $display("FAIL reset_man got=%h/%h want=0000/0000", bus.man_l, bus.man_s); end
    checks++; if (bus.out_exp !== 6'd0 || bus.exception !== 2'b00) begin failures++; $display("FAIL reset_exp_exc got=%0d/%b want=0/00", bus.out_exp, bus.exception); end
    checks++; if ({bus.sign_l, bus.sign_s, bus.swapped} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b want=000", {bus.sign_l, bus.sign_s, bus.swapped}); end
  endtask

  task automatic test_basic();
    int lat;
    run_op(16'h3C00, 16'h3800, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL basic_latency got=%0d want=2", lat); end
    checks++; if (bus.man_l !== 16'h1000) begin failures++; $display("FAIL basic_man_l got=%h want=1000", bus.man_l); end
    checks++; if (bus.man_s !== 16'h0800) begin failures++; $display("FAIL basic_man_s got=%h want=0800", bus.man_s); end
    checks++; if (bus.out_exp !== 6'd15) begin failures++; $display("FAIL basic_out_exp got=%0d want=15", bus.out_exp); end
    checks++; if (bus.swapped !== 1'b0 || bus.exception !== 2'b00) begin failures++; $display("FAIL basic_swap_exc got=%b/%b want=0/00", bus.swapped, bus.exception); end
    release_result();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin failures++; $display("FAIL basic_handshake got=%b/%b want=0/1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_swap();
    int lat;
    run_op(16'h3800, 16'h3C00, lat);
    checks++; if (lat != 2) begin failures++; $display("FAIL swap_latency got=%0d want=2", lat); end
    checks++; if (bus.swapped !== 1'b1) begin failures++; $display("FAIL swap_flag got=%b want=1", bus.swapped); end
    checks++; if (bus.sign_l !== 1'b0 || bus.sign_s !== 1'b0) begin failures++; $display("FAIL swap_signs got=%b/%b want=0/0", bus.sign_l, bus.sign_s); end
    checks++; if (bus.man_l !== 16'h1000 || bus.man_s !== 16'h0800) begin failures++; $display("FAIL swap_man got=%h/%h want=1000/0800", bus.man_l, bus.man_s); end
    release_result();
    // Negative smaller operand: sign follows the operand into the s slot.
    run_op(16'hB800, 16'h3C00, lat);
    checks++; if (bus.sign_l !== 1'b0 || bus.sign_s !== 1'b1 || bus.swapped !== 1'b1) begin failures++; $display("FAIL swap_neg got=%b/%b/%b want=0/1/1", bus.sign_l, bus.sign_s, bus.swapped); end
    release_result();
  endtask

  task automatic test_no_shift();
    int lat;
    // Equal exponents, a has larger fraction.
    run_op(16'h4100, 16'h4000, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL noshift_latency got=%0d want=1", lat); end
    checks++; if (bus.man_l !== 16'h1400 || bus.man_s !== 16'h1000) begin failures++; $display("FAIL noshift_man got=%h/%h want=1400/1000", bus.man_l, bus.man_s); end
    checks++; if (bus.out_exp !== 6'd16 || bus.swapped !== 1'b0) begin failures++; $display("FAIL noshift_exp_swap got=%0d/%b want=16/0", bus.out_exp, bus.swapped); end
    release_result();
    // Exact tie keeps a in the l slot.
    run_op(16'h3C00, 16'h3C00, lat);
    checks++; if (bus.swapped !== 1'b0 || lat != 1) begin failures++; $display("FAIL tie got=%b/%0d want=0/1", bus.swapped, lat); end
    release_result();
  endtask

  task automatic test_subnormal();
    int lat;
    // 0x0400: exp 1, hidden 1. 0x0200: subnormal, effective exp 1, no hidden bit.
    run_op(16'h0400, 16'h0200, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL subn_latency got=%0d want=1", lat); end
    checks++; if (bus.man_l !== 16'h1000 || bus.man_s !== 16'h0800) begin failures++; $display("FAIL subn_man got=%h/%h want=1000/0800", bus.man_l, bus.man_s); end
    checks++; if (bus.out_exp !== 6'd1) begin failures++; $display("FAIL subn_out_exp got=%0d want=1", bus.out_exp); end
    release_result();
  endtask

  task automatic test_sticky();
    int lat;
    logic [15:0] want_short, want_long;
`ifdef ALIGN_STICKY_EN
    want_short = 16'h0201;
    want_long  = 16'h0001;
`else
    want_short = 16'h0200;
    want_long  = 16'h0000;
`endif
    // d = 3: 0x1004 -> 0x0802 -> 0x0401 -> 0x0200 (+sticky 1).
    run_op(16'h4000, 16'h3401, lat);
    checks++; if (lat != 4) begin failures++; $display("FAIL d3_latency got=%0d want=4", lat); end
    checks++; if (bus.man_s !== want_short) begin failures++; $display("FAIL d3_man_s got=%h want=%h", bus.man_s, want_short); end
    release_result();
    // d = 19 capped at 13 shifts.
    run_op(16'h5000, 16'h0401, lat);
    checks++; if (lat != 14) begin failures++; $display("FAIL maxshift_latency got=%0d want=14", lat); end
    checks++; if (bus.out_exp !== 6'd20) begin failures++; $display("FAIL maxshift_out_exp got=%0d want=20", bus.out_exp); end
    checks++; if (bus.man_s !== want_long || bus.man_l !== 16'h1000) begin failures++; $display("FAIL maxshift_man got=%h/%h want=1000/%h", bus.man_l, bus.man_s, want_long); end
    release_result();
  endtask

  task automatic test_exception();
    int lat;
    run_op(16'h7C00, 16'h3C00, lat);
    checks++; if (lat != 1) begin failures++; $display("FAIL exc_latency got=%0d want=1", lat); end
    checks++; if (bus.exception !== 2'b10 || bus.out_exp !== 6'd31) begin failures++; $display("FAIL exc_code_exp got=%b/%0d want=10/31", bus.exception, bus.out_exp); end
    checks++; if (bus.man_l !== 16'h0000 || bus.man_s !== 16'h0000) begin failures++; $display("FAIL exc_man got=%h/%h want=0000/0000", bus.man_l, bus.man_s); end
    release_result();
    run_op(16'h3C00, 16'h7E00, lat);
    checks++; if (bus.exception !== 2'b10 || lat != 1) begin failures++; $display("FAIL exc_nan_b got=%b/%0d want=10/1", bus.exception, lat); end
    release_result();
    // Normal op after an exception clears the code.
    run_op(16'h3C00, 16'h3C00, lat);
    checks++; if (bus.exception !== 2'b00) begin failures++; $display("FAIL exc_clear got=%b want=00", bus.exception); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    int seen;
    run_op(16'h3C00, 16'h3800, lat);
    for (int i = 0; i < 5; i++) begin
      bus.a = 16'h4000;
      bus.b = 16'h3C00;
      bus.in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL hold_hs_%0d got=%b/%b want=1/0", i, bus.out_valid, bus.in_ready); end
      checks++; if (bus.man_l !== 16'h1000 || bus.man_s !== 16'h0800 || bus.out_exp !== 6'd15) begin failures++; $display("FAIL hold_data_%0d got=%h/%h/%0d want=1000/0800/15", i, bus.man_l, bus.man_s, bus.out_exp); end
    end
    bus.in_valid = 1'b0;
    release_result();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.out_valid) seen++;
      @(posedge clk);
      @(negedge clk);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL hold_no_queue got=%0d want=0", seen); end
  endtask

  task automatic test_reset_mid();
    int seen;
    // d = 10 (exp 19 vs exp 9).
    bus.a = 16'h4C00;
    bus.b = 16'h2400;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || bus.man_l !== 16'h0000) begin failures++; $display("FAIL midrst_clear got=%b/%h want=0/0000", bus.out_valid, bus.man_l); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid) seen++;
      @(negedge clk);
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_out_valid got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16'h4000, 16'h3C00, lat);
    release_result();
    run_op(16'h3C00, 16'h4000, lat);
    checks++; if (lat != 2 || bus.swapped !== 1'b1 || bus.man_s !== 16'h0800 || bus.out_exp !== 6'd16) begin failures++; $display("FAIL b2b got=%0d/%b/%h/%0d want=2/1/0800/16", lat, bus.swapped, bus.man_s, bus.out_exp); end
    release_result();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_swap();
    test_no_shift();
    test_subnormal();
    test_sticky();
    test_exception();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/align_mantissa.md
ALIGN_MANTISSA -- requirements
Module: align_mantissa

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1, operand pair offered.
REQ-004 SHALL have port in_ready, output, 1, block accepts operands this cycle.
REQ-005 SHALL have ports a, b, input, 16 each, IEEE half-precision operands {sign, exp[4:0], frac[9:0]}.
REQ-006 SHALL have port out_valid, output, 1, aligned result held.
REQ-007 SHALL have port out_ready, input, 1, consumer takes result.
REQ-008 SHALL have ports man_l, man_s, output, 16 each, aligned mantissas of larger and smaller operand: bit13 = 0 (carry room), bit12 = hidden, [11:2] = frac, bit1 = guard, bit0 = sticky.
REQ-009 SHALL have port out_exp, output, 6, larger effective exponent, zero-extended.
REQ-010 SHALL have ports sign_l, sign_s, swapped, output, 1 each; swapped = 1 when b was the larger operand.
REQ-011 SHALL have port exception, output, 2: 00 none, 10 operand exponent 31 (inf/NaN).

Function
REQ-012 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-013 SHALL on accept (in_valid & in_ready) register both operands, compare {exp, frac} magnitudes, and place the larger in the l slot; ties keep a as l, swapped = 0.
REQ-014 SHALL treat exp = 0 as subnormal: hidden bit 0, effective exponent 1.
REQ-015 SHALL compute d = exp_l - exp_s (effective) and shift man_s right one bit per SHIFT cycle for min(d, 13) cycles; man_l is never shifted.
REQ-016 SHALL skip SHIFT when d = 0; out_valid asserts 1 cycle after accept, else 1 + min(d, 13) cycles after accept.
REQ-017 SHALL, when either exponent = 31, skip SHIFT, set exception = 10, output mantissas 0 and out_exp = 31, out_valid 1 cycle after accept.
REQ-018 SHALL hold all outputs stable in DONE while out_valid & !out_ready; DONE -> IDLE on out_ready.
REQ-019 SHALL ignore in_valid while not IDLE (no queueing); next accept at earliest the cycle after out_valid & out_ready.
REQ-020 SHALL keep bit13 of both outputs 0 and never produce out_exp > 31.

Reset
REQ-021 SHALL on rst_n low immediately enter IDLE, drive out_valid = 0, in_ready = 1 after release, and clear man_l, man_s, out_exp, signs, swapped, exception to 0.
REQ-022 SHALL discard any in-flight operation on reset mid-SHIFT or mid-DONE; no output handshake follows.

Configuration
REQ-023 SHALL honour macro ALIGN_STICKY_EN: defined -> every bit shifted out of bit0 is ORed into bit0 (sticky); undefined -> bit0 is a plain shift position and shifted-out bits are dropped (truncation).

Structure
REQ-024 SHALL take from shared package fp16_pkg: field widths (EXP_W = 5, FRAC_W = 10, MAN_W = 16), EXP_MAX = 31, MAX_SHIFT = 13, exception codes, FSM state typedef.
REQ-025 SHALL use one sub-module exp_compare (combinational magnitude compare, swap, exponent difference).

Verification
REQ-026 SHALL check a = 0x3C00, b = 0x3800 -> man_l = 0x1000, man_s = 0x0800, out_exp = 15, swapped = 0, out_valid 2 cycles after accept.
REQ-027 SHALL check a = 0x3800, b = 0x3C00 -> swapped = 1, sign_l = sign_s = 0, same mantissas as REQ-026.
REQ-028 SHALL check a = 0x5000, b = 0x0401 -> out_exp = 20, man_s = 0x0001 with ALIGN_STICKY_EN, 0x0000 without, out_valid 14 cycles after accept.
REQ-029 SHALL check a = 0x7C00, b = 0x3C00 -> exception = 10, out_exp = 31, out_valid 1 cycle after accept.
REQ-030 SHALL check out_ready held 0 for 5 cycles in DONE -> outputs unchanged, in_ready = 0, new in_valid ignored.
REQ-031 SHALL check rst_n pulsed low during SHIFT of a d = 10 operation -> out_valid never asserts, in_ready = 1 the cycle after release.
